// File: rtl/binary_math_round_ctrl.sv
// Round-based addition game controller: draws a pseudo-random operand, times the
// player with a BCD countdown, scores answers whose sum hits TARGET.
module binary_math_round_ctrl #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned TARGET        = (2 ** WIDTH) - 1,
    parameter int unsigned ROUNDS        = 5,
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned TIME_LIMIT    = 15
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Submit,
    input  logic [WIDTH-1:0] PlayerIn,
    output logic [WIDTH-1:0] RngVal,
    output logic [WIDTH-1:0] PlayerVal,
    output logic [WIDTH:0]   Sum,
    output logic [1:0]       Match,
    output logic [3:0]       Score,
    output logic [3:0]       Round,
    output logic [3:0]       Tens,
    output logic [3:0]       Ones,
    output logic             Playing,
    output logic             GameOver
);

    localparam int unsigned PRE_W = $clog2(TICKS_PER_SEC);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [WIDTH:0]   TARGET_V  = (WIDTH + 1)'(TARGET);
    localparam logic [3:0]       ROUNDS_V  = 4'(ROUNDS);
    localparam logic [3:0]       TENS_INIT = 4'(TIME_LIMIT / 10);
    localparam logic [3:0]       ONES_INIT = 4'(TIME_LIMIT % 10);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;

    localparam logic [1:0] MATCH_NONE = 2'b00;
    localparam logic [1:0] MATCH_WIN  = 2'b10;
    localparam logic [1:0] MATCH_LOSE = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_PLAY,
        S_RESULT,
        S_DONE
    } state_t;

    state_t           state_q,  state_d;
    logic [15:0]      lfsr_q,   lfsr_d;
    logic [WIDTH-1:0] rng_q,    rng_d;
    logic [WIDTH-1:0] player_q, player_d;
    logic [WIDTH:0]   sum_q,    sum_d;
    logic [1:0]       match_q,  match_d;
    logic [3:0]       score_q,  score_d;
    logic [3:0]       round_q,  round_d;
    logic [3:0]       tens_q,   tens_d;
    logic [3:0]       ones_q,   ones_d;
    logic [PRE_W-1:0] pre_q,    pre_d;

    logic             lfsr_fb;
    logic [WIDTH:0]   answer_sum;
    logic             timer_zero;

    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign answer_sum = {1'b0, PlayerIn} + {1'b0, rng_q};
    assign timer_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = {lfsr_q[14:0], lfsr_fb};
        rng_d    = rng_q;
        player_d = player_q;
        sum_d    = sum_q;
        match_d  = match_q;
        score_d  = score_q;
        round_d  = round_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        pre_d    = pre_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_DRAW;
                    round_d = 4'd1;
                    score_d = 4'd0;
                end
            end

            S_DRAW: begin
                rng_d    = lfsr_q[WIDTH-1:0];
                player_d = '0;
                sum_d    = '0;
                match_d  = MATCH_NONE;
                tens_d   = TENS_INIT;
                ones_d   = ONES_INIT;
                pre_d    = '0;
                state_d  = S_PLAY;
            end

            S_PLAY: begin
                // An answer wins over an expired timer; the timer only ticks while undecided.
                if (Submit) begin
                    player_d = PlayerIn;
                    sum_d    = answer_sum;
                    if (answer_sum == TARGET_V) begin
                        match_d = MATCH_WIN;
                        score_d = score_q + 4'd1;
                    end else begin
                        match_d = MATCH_LOSE;
                    end
                    state_d = S_RESULT;
                end else if (timer_zero) begin
                    match_d = MATCH_LOSE;
                    state_d = S_RESULT;
                end else if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end

            S_RESULT: begin
                if (Start) begin
                    if (round_q < ROUNDS_V) begin
                        round_d = round_q + 4'd1;
                        state_d = S_DRAW;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (Start) begin
                    state_d = S_DRAW;
                    round_d = 4'd1;
                    score_d = 4'd0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            lfsr_q   <= LFSR_SEED;
            rng_q    <= '0;
            player_q <= '0;
            sum_q    <= '0;
            match_q  <= '0;
            score_q  <= '0;
            round_q  <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
            pre_q    <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            rng_q    <= rng_d;
            player_q <= player_d;
            sum_q    <= sum_d;
            match_q  <= match_d;
            score_q  <= score_d;
            round_q  <= round_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            pre_q    <= pre_d;
        end
    end

    assign RngVal    = rng_q;
    assign PlayerVal = player_q;
    assign Sum       = sum_q;
    assign Match     = match_q;
    assign Score     = score_q;
    assign Round     = round_q;
    assign Tens      = tens_q;
    assign Ones      = ones_q;
    assign Playing   = (state_q == S_PLAY);
    assign GameOver  = (state_q == S_DONE);

endmodule

// File: tb/tb_binary_math_round_ctrl.sv
// Directed bench for binary_math_round_ctrl with a 3-round, 3-second, 4-tick game.
module tb_binary_math_round_ctrl;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       Submit;
    logic [3:0] PlayerIn;
    logic [3:0] RngVal;
    logic [3:0] PlayerVal;
    logic [4:0] Sum;
    logic [1:0] Match;
    logic [3:0] Score;
    logic [3:0] Round;
    logic [3:0] Tens;
    logic [3:0] Ones;
    logic       Playing;
    logic       GameOver;

    int checks = 0;
    int errors = 0;

    logic [15:0] lfsr_m;
    logic [32:0] all_outs;

    binary_math_round_ctrl #(
        .WIDTH(4),
        .TARGET(15),
        .ROUNDS(3),
        .TICKS_PER_SEC(4),
        .TIME_LIMIT(3)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Start(Start),
        .Submit(Submit),
        .PlayerIn(PlayerIn),
        .RngVal(RngVal),
        .PlayerVal(PlayerVal),
        .Sum(Sum),
        .Match(Match),
        .Score(Score),
        .Round(Round),
        .Tens(Tens),
        .Ones(Ones),
        .Playing(Playing),
        .GameOver(GameOver)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference x^16+x^14+x^13+x^11+1 sequence, advancing every cycle from the seed.
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) lfsr_m <= 16'hACE1;
        else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    assign all_outs = {RngVal, PlayerVal, Sum, Match, Score, Round, Tens, Ones, Playing, GameOver};

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b0; Submit = 1'b0; PlayerIn = 4'd0;
        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if (all_outs !== 33'd0) begin
            errors++; $display("FAIL reset_outputs got %h expected 0", all_outs);
        end
        Reset = 1'b1;
        Submit = 1'b1; PlayerIn = 4'd9;
        tick();
        Submit = 1'b0;
        tick();
        checks++;
        if (all_outs !== 33'd0) begin
            errors++; $display("FAIL idle_submit_ignored got %h expected 0", all_outs);
        end
    endtask

    task automatic test_win();
        logic [3:0] r;
        int pv;
        pulse_start();
        checks++;
        if ({Round, Score, Playing, GameOver} !== {4'd1, 4'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL win_draw got R%0d S%0d P%0d G%0d expected R1 S0 P0 G0", Round, Score, Playing, GameOver);
        end
        r = lfsr_m[3:0];
        tick();
        checks++;
        if ({RngVal, Playing, Tens, Ones, Match, Sum, PlayerVal} !== {r, 1'b1, 4'd0, 4'd3, 2'b00, 5'd0, 4'd0}) begin
            errors++; $display("FAIL win_play_entry got rng %0d play %0d t%0d%0d m%b sum %0d pv %0d expected rng %0d play 1 t03 m00 sum 0 pv 0",
                              RngVal, Playing, Tens, Ones, Match, Sum, PlayerVal, r);
        end
        pv = 15 - int'(r);
        PlayerIn = pv[3:0]; Submit = 1'b1;
        tick();
        Submit = 1'b0;
        checks++;
        if ({Match, Sum, Score, Round, PlayerVal, Playing} !== {2'b10, 5'd15, 4'd1, 4'd1, pv[3:0], 1'b0}) begin
            errors++; $display("FAIL win_result got m%b sum %0d score %0d round %0d pv %0d play %0d expected m10 sum 15 score 1 round 1 pv %0d play 0",
                              Match, Sum, Score, Round, PlayerVal, Playing, pv);
        end
        PlayerIn = ~PlayerIn; Submit = 1'b1;
        tick();
        Submit = 1'b0;
        tick();
        checks++;
        if ({Match, Sum, Score, PlayerVal} !== {2'b10, 5'd15, 4'd1, pv[3:0]}) begin
            errors++; $display("FAIL result_hold got m%b sum %0d score %0d pv %0d expected m10 sum 15 score 1 pv %0d",
                              Match, Sum, Score, PlayerVal, pv);
        end
    endtask

    task automatic test_lose();
        logic [3:0] r;
        logic [4:0] exp_sum;
        int pv;
        pulse_start();
        r = lfsr_m[3:0];
        tick();
        checks++;
        if ({RngVal, Round, Score} !== {r, 4'd2, 4'd1}) begin
            errors++; $display("FAIL lose_entry got rng %0d round %0d score %0d expected rng %0d round 2 score 1", RngVal, Round, Score, r);
        end
        pv = (16 - int'(r)) % 16;
        exp_sum = (r == 4'd0) ? 5'd0 : 5'd16;
        PlayerIn = pv[3:0]; Submit = 1'b1;
        tick();
        Submit = 1'b0;
        checks++;
        if ({Match, Sum, Score, Round, PlayerVal} !== {2'b01, exp_sum, 4'd1, 4'd2, pv[3:0]}) begin
            errors++; $display("FAIL lose_result got m%b sum %0d score %0d round %0d pv %0d expected m01 sum %0d score 1 round 2 pv %0d",
                              Match, Sum, Score, Round, PlayerVal, exp_sum, pv);
        end
    endtask

    task automatic test_submit_at_zero();
        logic [3:0] r;
        int pv;
        pulse_start();
        r = lfsr_m[3:0];
        tick();
        repeat (12) tick();
        checks++;
        if ({Tens, Ones, Playing, Round} !== {4'd0, 4'd0, 1'b1, 4'd3}) begin
            errors++; $display("FAIL zero_reached got t%0d%0d play %0d round %0d expected t00 play 1 round 3", Tens, Ones, Playing, Round);
        end
        pv = 15 - int'(r);
        PlayerIn = pv[3:0]; Submit = 1'b1;
        tick();
        Submit = 1'b0;
        checks++;
        if ({Match, Sum, Score, PlayerVal} !== {2'b10, 5'd15, 4'd2, pv[3:0]}) begin
            errors++; $display("FAIL zero_submit got m%b sum %0d score %0d pv %0d expected m10 sum 15 score 2 pv %0d",
                              Match, Sum, Score, PlayerVal, pv);
        end
    endtask

    task automatic test_game_over();
        logic [3:0] r;
        pulse_start();
        checks++;
        if ({GameOver, Playing, Score, Round, Match} !== {1'b1, 1'b0, 4'd2, 4'd3, 2'b10}) begin
            errors++; $display("FAIL game_over got g%0d p%0d score %0d round %0d m%b expected g1 p0 score 2 round 3 m10",
                              GameOver, Playing, Score, Round, Match);
        end
        Submit = 1'b1; PlayerIn = 4'd1;
        tick();
        Submit = 1'b0;
        tick();
        checks++;
        if ({GameOver, Score, Sum, Round} !== {1'b1, 4'd2, 5'd15, 4'd3}) begin
            errors++; $display("FAIL done_hold got g%0d score %0d sum %0d round %0d expected g1 score 2 sum 15 round 3",
                              GameOver, Score, Sum, Round);
        end
        pulse_start();
        checks++;
        if ({GameOver, Playing, Round, Score} !== {1'b0, 1'b0, 4'd1, 4'd0}) begin
            errors++; $display("FAIL new_game_draw got g%0d p%0d round %0d score %0d expected g0 p0 round 1 score 0",
                              GameOver, Playing, Round, Score);
        end
        r = lfsr_m[3:0];
        tick();
        checks++;
        if ({Playing, RngVal, Tens, Ones, Match, PlayerVal, Sum} !== {1'b1, r, 4'd0, 4'd3, 2'b00, 4'd0, 5'd0}) begin
            errors++; $display("FAIL new_game_play got p%0d rng %0d t%0d%0d m%b pv %0d sum %0d expected p1 rng %0d t03 m00 pv 0 sum 0",
                              Playing, RngVal, Tens, Ones, Match, PlayerVal, Sum, r);
        end
    endtask

    task automatic test_timeout();
        int e;
        for (int i = 0; i <= 12; i++) begin
            Start = (i == 1);
            e = 3 - i / 4;
            checks++;
            if ({Tens, Ones} !== {4'd0, e[3:0]}) begin
                errors++; $display("FAIL countdown_%0d got t%0d%0d expected t0%0d", i, Tens, Ones, e);
            end
            if (i < 12) tick();
        end
        Start = 1'b0;
        tick();
        checks++;
        if ({Match, PlayerVal, Sum, Playing, Round, Tens, Ones} !== {2'b01, 4'd0, 5'd0, 1'b0, 4'd1, 4'd0, 4'd0}) begin
            errors++; $display("FAIL timeout_result got m%b pv %0d sum %0d p%0d round %0d t%0d%0d expected m01 pv 0 sum 0 p0 round 1 t00",
                              Match, PlayerVal, Sum, Playing, Round, Tens, Ones);
        end
        repeat (6) tick();
        checks++;
        if ({Tens, Ones, Match, Score} !== {4'd0, 4'd0, 2'b01, 4'd0}) begin
            errors++; $display("FAIL timer_frozen got t%0d%0d m%b score %0d expected t00 m01 score 0", Tens, Ones, Match, Score);
        end
    endtask

    task automatic test_reset_mid_round();
        logic [3:0] r;
        int pv;
        pulse_start();
        r = lfsr_m[3:0];
        tick();
        pv = 15 - int'(r);
        PlayerIn = pv[3:0]; Submit = 1'b1;
        tick();
        Submit = 1'b0;
        pulse_start();
        tick();
        tick();
        checks++;
        if ({Playing, Score, Round} !== {1'b1, 4'd1, 4'd3}) begin
            errors++; $display("FAIL pre_reset got p%0d score %0d round %0d expected p1 score 1 round 3", Playing, Score, Round);
        end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (all_outs !== 33'd0) begin
            errors++; $display("FAIL async_reset got %h expected 0", all_outs);
        end
        Start = 1'b1; Submit = 1'b1; PlayerIn = 4'd15;
        repeat (2) tick();
        checks++;
        if (all_outs !== 33'd0) begin
            errors++; $display("FAIL reset_held got %h expected 0", all_outs);
        end
        Start = 1'b0; Submit = 1'b0;
        Reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (all_outs !== 33'd0) begin
            errors++; $display("FAIL idle_after_reset got %h expected 0", all_outs);
        end
        pulse_start();
        checks++;
        if ({Round, Score, Playing, GameOver} !== {4'd1, 4'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL restart_draw got round %0d score %0d p%0d g%0d expected round 1 score 0 p0 g0",
                              Round, Score, Playing, GameOver);
        end
        tick();
        checks++;
        if ({Playing, Tens, Ones} !== {1'b1, 4'd0, 4'd3}) begin
            errors++; $display("FAIL restart_play got p%0d t%0d%0d expected p1 t03", Playing, Tens, Ones);
        end
    endtask

    initial begin
        test_reset();
        test_win();
        test_lose();
        test_submit_at_zero();
        test_game_over();
        test_timeout();
        test_reset_mid_round();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/binary_math_round_ctrl.md
BINARY_MATH_ROUND_CTRL -- requirements
Module: binary_math_round_ctrl

Interface
REQ-001 Parameter WIDTH, 4, operand width in bits; legal range 2..16.
REQ-002 Parameter TARGET, (2**WIDTH)-1, sum that wins a round; legal range 0..2**(WIDTH+1)-2.
REQ-003 Parameter ROUNDS, 5, rounds per game; legal range 1..15.
REQ-004 Parameter TICKS_PER_SEC, 50000000, clock cycles per timer second; minimum 2.
REQ-005 Parameter TIME_LIMIT, 15, seconds per round; legal range 1..99.
REQ-006 Clock  in  1  system clock; all state updates on its rising edge.
REQ-007 Reset  in  1  asynchronous, active-low reset.
REQ-008 Start  in  1  single-cycle pulse, already debounced and shaped: begin game / advance round.
REQ-009 Submit  in  1  single-cycle pulse, already shaped: commit player answer.
REQ-010 PlayerIn  in  WIDTH  player switch value.
REQ-011 RngVal  out  WIDTH  random operand for the current round.
REQ-012 PlayerVal  out  WIDTH  committed player operand.
REQ-013 Sum  out  WIDTH+1  PlayerVal+RngVal, no truncation.
REQ-014 Match  out  2  bit1 = win, bit0 = lose; 00 = no result.
REQ-015 Score  out  4  rounds won in the current game.
REQ-016 Round  out  4  current round number, 1-based; 0 in IDLE.
REQ-017 Tens, Ones  out  4 each  BCD countdown digits.
REQ-018 Playing  out  1  high only in PLAY.
REQ-019 GameOver  out  1  high only in DONE.

Function
REQ-020 States SHALL be IDLE, DRAW, PLAY, RESULT and DONE.
REQ-021 IDLE: Start moves to DRAW with Round=1 and Score=0; Submit is ignored.
REQ-022 A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) SHALL advance every cycle in every state, so it never holds zero.
REQ-023 DRAW lasts exactly one cycle:
- RngVal takes LFSR[WIDTH-1:0].
- PlayerVal, Sum and Match clear to 0.
- Tens:Ones load TIME_LIMIT/10 : TIME_LIMIT%10.
- Prescaler clears to 0.
- Next state is PLAY.
REQ-024 PLAY: the prescaler counts 0..TICKS_PER_SEC-1 and wraps; on each wrap the BCD pair decrements (Ones 0 becomes 9 with Tens-1; otherwise Ones-1).
REQ-025 PLAY, Submit sampled at edge n; all of the following are visible after edge n (one-cycle latency):
- PlayerVal = PlayerIn and Sum = PlayerIn+RngVal.
- Match = 10 if that sum equals TARGET, else 01.
- Score increments on a win.
- State becomes RESULT.
REQ-026 PLAY with Tens:Ones = 00 and no Submit: the next edge gives Match = 01, PlayerVal and Sum remain 0, and state becomes RESULT.
REQ-027 Submit and a 00 timer in the same cycle SHALL be treated as a Submit.
REQ-028 The timer SHALL stop at 00, never wrap, and freeze its value outside PLAY.
REQ-029 RESULT: Match, Sum, PlayerVal, timer digits and Score hold; Submit is ignored.
REQ-030 RESULT, on Start: if Round < ROUNDS, Round increments and state becomes DRAW; if Round = ROUNDS, state becomes DONE.
REQ-031 DONE: all outputs hold, GameOver = 1, Submit is ignored.
REQ-032 DONE, on Start: state becomes DRAW with Round=1, Score=0 (new game).
REQ-033 Start during DRAW or PLAY SHALL be ignored.
REQ-034 Score never exceeds ROUNDS, so no saturation logic is required.

Reset
REQ-035 Reset low SHALL immediately force:
- State IDLE; LFSR = 16'hACE1.
- RngVal, PlayerVal, Sum, Match, Score, Round, Tens, Ones and prescaler = 0.
- Playing = 0 and GameOver = 0.
REQ-036 Reset asserted mid-round SHALL abandon the round with no Score change retained; after release the block stays in IDLE until Start.

Verification (WIDTH=4, TARGET=15, ROUNDS=3, TICKS_PER_SEC=4, TIME_LIMIT=3)
REQ-037 Reset, Start, then Submit with PlayerIn = 15-RngVal -> Match=10, Sum=15, Score=1, Round=1, one cycle after Submit.
REQ-038 Start, then Submit with PlayerIn = (16-RngVal)%16 -> Match=01, Sum=16 (or 0 if RngVal=0), Score unchanged.
REQ-039 Start, then no Submit -> Tens:Ones steps 03,02,01,00 every 4 cycles; one cycle after reaching 00, Match=01, PlayerVal=0, timer frozen at 00.
REQ-040 Submit in the exact cycle the timer reads 00 -> treated as Submit; Match reflects Sum vs TARGET.
REQ-041 Three rounds, two of them won -> GameOver=1, Score=2, Round=3; the next Start gives Round=1, Score=0, state DRAW.
REQ-042 Reset pulsed low during PLAY with Score=1 -> all outputs 0 immediately; Start and Submit both ignored while Reset is low; the first Start after release begins a new game at Round=1.
